oled_spi_tx: RTL and testbench

//  Byte-stream SPI master driving the SSD1306 4-wire interface (ss, scl, mosi, dc).

---
 rtl/oled_spi_pkg.sv | 40 ++++
 rtl/oled_spi_phase_ctr.sv | 48 ++++
 rtl/oled_spi_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_oled_spi_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_spi_pkg.sv
// -----------------------------------------------------------------------------
// oled_spi_pkg
//  Shared definitions for the SSD1306 4-wire SPI transmit path.
//  Contents:
//   oled_spi_state_t        byte-serialiser FSM states
//   SPI_CPOL / SPI_CPHA     SPI mode 0 (scl idles low, sample on rising edge)
//   DEF_CLK_DIV / DEF_CS_*  default timing parameters for a 16 MHz clk_avr_16
//   max3 / phase_width      sizing helpers for the shared phase counter
// -----------------------------------------------------------------------------
package oled_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_HOLD   = 3'd4,
    ST_GAP    = 3'd5
  } oled_spi_state_t;

  // Mode 0: clock idles low, data sampled by the panel on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int DEF_CLK_DIV  = 1;
  localparam int DEF_CS_SETUP = 1;
  localparam int DEF_CS_HOLD  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width needed to hold the longest phase length itself.
  function automatic int phase_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/oled_spi_phase_ctr.sv
// -----------------------------------------------------------------------------
// oled_spi_phase_ctr
//  Loadable down-counter timing every scl/ss phase of the transmitter.
//  Loading a length L makes tc rise on the L-th cycle after the load, i.e.
//  on the last cycle the FSM spends in that phase. The counter rests at zero
//  (tc=1) between phases; the FSM reloads it on every phase entry.
//  Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   load      in   start a new phase this cycle
//   load_val  in   phase length in cycles (>= 1)
//   tc        out  terminal count: current cycle is the last of the phase
// -----------------------------------------------------------------------------
module oled_spi_phase_ctr
  import oled_spi_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val - 1'b1;
    end else if (count_reg != '0) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/oled_spi_tx.sv
// -----------------------------------------------------------------------------
// oled_spi_tx
//  Byte-stream SPI master for the SSD1306 4-wire interface (mode 0, MSB first).
//  A one-entry holding register sits in front of the shift register, so the
//  next byte can be accepted while the current one shifts; consecutive bytes
//  of a burst go out back-to-back with ss held low.
//  Parameters:
//   CLK_DIV   scl half-period in clk_avr_16 cycles (>= 1)
//   CS_SETUP  cycles of ss low before the first scl rise of a burst (>= 1)
//   CS_HOLD   cycles after the final scl fall before ss rises (>= 1)
//  Ports:
//   clk_avr_16  in   16 MHz system clock
//   oled_reset  in   asynchronous active-low reset
//   tx_valid    in   byte offered
//   tx_ready    out  holding register empty (accept on tx_valid & tx_ready)
//   tx_data     in   byte to send
//   tx_dc       in   0 = command, 1 = data; travels with its byte
//   tx_last     in   release ss after this byte
//   busy        out  ss asserted or a byte pending
//   ss          out  chip select, active low
//   scl         out  serial clock, idles low
//   mosi        out  serial data
//   dc          out  data/command select
// -----------------------------------------------------------------------------
module oled_spi_tx
  import oled_spi_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD
) (
  input  logic       clk_avr_16,
  input  logic       oled_reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  output logic       busy,
  output logic       ss,
  output logic       scl,
  output logic       mosi,
  output logic       dc
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("oled_spi_tx: CLK_DIV must be >= 1");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("oled_spi_tx: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("oled_spi_tx: CS_HOLD must be >= 1");
  end
  if (SPI_CPHA != 1'b0) begin : g_bad_cpha
    $error("oled_spi_tx: only CPHA=0 timing is implemented");
  end

  localparam int PH_W = phase_width(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam logic [PH_W-1:0] PH_CLK_DIV  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_CS_SETUP = PH_W'(CS_SETUP);
  localparam logic [PH_W-1:0] PH_CS_HOLD  = PH_W'(CS_HOLD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  oled_spi_state_t state_reg;

  logic       hold_full_reg;
  logic [7:0] hold_data_reg;
  logic       hold_dc_reg;
  logic       hold_last_reg;
  logic       tx_ready_reg;

  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [2:0] bit_cnt_reg;
  logic       cur_last_reg;
  logic       ss_reg;
  logic       scl_reg;
  logic       dc_reg;

  logic       accept;
  logic       byte_done;
  logic       chain_next;
  logic       load_byte;
  logic       hold_full_next;

  logic            ctr_load;
  logic [PH_W-1:0] ctr_val;
  logic            ctr_tc;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  // MSB-first shift: bit 7 always holds the bit currently on mosi.
  assign shift_next[0] = 1'b0;
  for (genvar gi = 1; gi < 8; gi++) begin : g_shift
    assign shift_next[gi] = shift_reg[gi-1];
  end

  assign accept     = tx_valid & tx_ready_reg;
  // Last cycle of the high half of bit 0.
  assign byte_done  = (state_reg == ST_BIT_HI) & ctr_tc & (bit_cnt_reg == 3'd0);
  // Continue the burst without releasing ss when a byte is already waiting.
  assign chain_next = byte_done & ~cur_last_reg & hold_full_reg;
  assign load_byte  = ((state_reg == ST_IDLE) & hold_full_reg) | chain_next;

  // A byte accepted while the held one is being loaded simply refills the slot.
  assign hold_full_next = accept | (hold_full_reg & ~load_byte);

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_avr_16 or negedge oled_reset) begin
    if (!oled_reset) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= 8'h00;
      hold_dc_reg   <= 1'b0;
      hold_last_reg <= 1'b0;
      tx_ready_reg  <= 1'b1;
    end else begin
      if (accept) begin
        hold_data_reg <= tx_data;
        hold_dc_reg   <= tx_dc;
        hold_last_reg <= tx_last;
      end
      hold_full_reg <= hold_full_next;
      tx_ready_reg  <= ~hold_full_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter control: reload on every phase entry
  // ---------------------------------------------------------------------------
  always_comb begin
    ctr_load = 1'b0;
    ctr_val  = PH_CLK_DIV;
    case (state_reg)
      ST_IDLE: begin
        if (hold_full_reg) begin
          ctr_load = 1'b1;
          ctr_val  = PH_CS_SETUP;
        end
      end
      ST_SETUP, ST_BIT_LO: begin
        if (ctr_tc) begin
          ctr_load = 1'b1;
        end
      end
      ST_BIT_HI: begin
        if (ctr_tc) begin
          ctr_load = 1'b1;
          if (byte_done & ~chain_next) begin
            ctr_val = PH_CS_HOLD;
          end
        end
      end
      default: begin
        ctr_load = 1'b0;
      end
    endcase
  end

  oled_spi_phase_ctr #(
    .WIDTH (PH_W)
  ) u_phase_ctr (
    .clk      (clk_avr_16),
    .rst_n    (oled_reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .tc       (ctr_tc)
  );

  // ---------------------------------------------------------------------------
  // Serialiser FSM (all pin outputs registered here)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_avr_16 or negedge oled_reset) begin
    if (!oled_reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= 8'h00;
      bit_cnt_reg  <= 3'd0;
      cur_last_reg <= 1'b0;
      ss_reg       <= 1'b1;
      scl_reg      <= SPI_CPOL;
      dc_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (hold_full_reg) begin
            shift_reg    <= hold_data_reg;
            dc_reg       <= hold_dc_reg;
            cur_last_reg <= hold_last_reg;
            bit_cnt_reg  <= 3'd7;
            ss_reg       <= 1'b0;
            state_reg    <= ST_SETUP;
          end
        end
        // The first bit's low phase is the ss setup time itself.
        ST_SETUP, ST_BIT_LO: begin
          if (ctr_tc) begin
            scl_reg   <= 1'b1;
            state_reg <= ST_BIT_HI;
          end
        end
        ST_BIT_HI: begin
          if (ctr_tc) begin
            scl_reg <= 1'b0;
            if (chain_next) begin
              // dc and mosi change together with the falling scl edge.
              shift_reg    <= hold_data_reg;
              dc_reg       <= hold_dc_reg;
              cur_last_reg <= hold_last_reg;
              bit_cnt_reg  <= 3'd7;
              state_reg    <= ST_BIT_LO;
            end else if (byte_done) begin
              // Last byte or underrun: always close the burst.
              state_reg <= ST_HOLD;
            end else begin
              shift_reg   <= shift_next;
              bit_cnt_reg <= bit_cnt_reg - 1'b1;
              state_reg   <= ST_BIT_LO;
            end
          end
        end
        ST_HOLD: begin
          if (ctr_tc) begin
            ss_reg    <= 1'b1;
            state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Guaranteed ss-high cycle so the panel sees a deselect between bursts.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_reg;
  assign busy     = (state_reg != ST_IDLE) | hold_full_reg;
  assign ss       = ss_reg;
  assign scl      = scl_reg;
  assign mosi     = shift_reg[7];
  assign dc       = dc_reg;

endmodule

// File: tb/tb_oled_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_oled_spi_tx
//  Directed bench for oled_spi_tx. Instance 0 runs at CLK_DIV=1, instance 1 at
//  CLK_DIV=4. A receiver model per instance samples mosi/dc on each scl rise
//  while ss is low, realigns whenever ss is high, and logs rise cycles.
// -----------------------------------------------------------------------------
module tb_oled_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] vld;
  logic [7:0] dat [2];
  logic [1:0] dcin;
  logic [1:0] lst;
  logic [1:0] rdy_o, busy_o, ss_o, scl_o, mosi_o, dc_o;

  oled_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut0 (
    .clk_avr_16 (clk),
    .oled_reset (rst_n),
    .tx_valid   (vld[0]),
    .tx_ready   (rdy_o[0]),
    .tx_data    (dat[0]),
    .tx_dc      (dcin[0]),
    .tx_last    (lst[0]),
    .busy       (busy_o[0]),
    .ss         (ss_o[0]),
    .scl        (scl_o[0]),
    .mosi       (mosi_o[0]),
    .dc         (dc_o[0])
  );

  oled_spi_tx #(.CLK_DIV(4), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (
    .clk_avr_16 (clk),
    .oled_reset (rst_n),
    .tx_valid   (vld[1]),
    .tx_ready   (rdy_o[1]),
    .tx_data    (dat[1]),
    .tx_dc      (dcin[1]),
    .tx_last    (lst[1]),
    .busy       (busy_o[1]),
    .ss         (ss_o[1]),
    .scl        (scl_o[1]),
    .mosi       (mosi_o[1]),
    .dc         (dc_o[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int last_acc = 0;

  // ---------------------------------------------------------------------------
  // Receiver model (SSD1306 side)
  // ---------------------------------------------------------------------------
  int         rx_cnt   [2] = '{0, 0};
  logic [7:0] rx_sh    [2] = '{8'h00, 8'h00};
  logic       rx_dc    [2] = '{1'b0, 1'b0};
  int         ss_falls [2] = '{0, 0};
  int         sig_bad  [2] = '{0, 0};
  logic [1:0] ss_p = 2'b11, scl_p = 2'b00, mosi_p = 2'b00, dc_p = 2'b00;
  logic [8:0] rx_q0 [$];
  logic [8:0] rx_q1 [$];
  int         rise_q0 [$];
  int         rise_q1 [$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ss_o[i]) begin
        rx_cnt[i] = 0;
      end else begin
        if (ss_p[i]) ss_falls[i]++;
        // mosi/dc must never move while scl is (or just went) high.
        if (scl_o[i] && ((mosi_o[i] != mosi_p[i]) || (dc_o[i] != dc_p[i]))) sig_bad[i]++;
        if (scl_o[i] && !scl_p[i]) begin
          if (rx_cnt[i] == 0) rx_dc[i] = dc_o[i];
          else if (dc_o[i] != rx_dc[i]) sig_bad[i]++;
          rx_sh[i] = {rx_sh[i][6:0], mosi_o[i]};
          if (i == 0) rise_q0.push_back(cyc);
          else        rise_q1.push_back(cyc);
          rx_cnt[i]++;
          if (rx_cnt[i] == 8) begin
            rx_cnt[i] = 0;
            if (i == 0) rx_q0.push_back({rx_dc[i], rx_sh[i]});
            else        rx_q1.push_back({rx_dc[i], rx_sh[i]});
            $display("rx%0d cyc=%0d dc=%0b byte=%02h", i, cyc, rx_dc[i], rx_sh[i]);
          end
        end
      end
      ss_p[i]   = ss_o[i];
      scl_p[i]  = scl_o[i];
      mosi_p[i] = mosi_o[i];
      dc_p[i]   = dc_o[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  // Offer one byte on instance 0; returns on the cycle after the accept.
  task automatic send0(input logic [7:0] d, input logic dcv, input logic lastv);
    int budget;
    budget = 300;
    while (!rdy_o[0] && budget > 0) begin
      tick();
      budget--;
    end
    chk("send0_ready", rdy_o[0], 1);
    dat[0]   = d;
    dcin[0]  = dcv;
    lst[0]   = lastv;
    vld[0]   = 1'b1;
    last_acc = cyc;
    tick();
    vld[0]   = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int inst, input int n, input int budget);
    int b;
    b = budget;
    while ((((inst == 0) ? rx_q0.size() : rx_q1.size()) < n) && b > 0) begin
      tick();
      b--;
    end
    chk(tag, (inst == 0) ? rx_q0.size() : rx_q1.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int inst);
    int b;
    b = 1000;
    while ((busy_o[inst] || !ss_o[inst]) && b > 0) begin
      tick();
      b--;
    end
    chk(tag, busy_o[inst], 0);
  endtask

  task automatic clear_logs();
    rx_q0.delete();
    rx_q1.delete();
    rise_q0.delete();
    rise_q1.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int         t0;
    int         k;
    int         budget;
    int         falls0;
    int         acc3 [4];
    logic [7:0] bytes3 [4];

    rst_n  = 1'b0;
    vld    = 2'b00;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    dcin   = 2'b00;
    lst    = 2'b00;
    tick();
    tick();

    // Reset state
    chk("rst_ss",    ss_o[0],   1);
    chk("rst_scl",   scl_o[0],  0);
    chk("rst_mosi",  mosi_o[0], 0);
    chk("rst_dc",    dc_o[0],   0);
    chk("rst_busy",  busy_o[0], 0);
    chk("rst_ready", rdy_o[0],  1);
    chk("rst_ss1",   ss_o[1],   1);
    chk("rst_rdy1",  rdy_o[1],  1);
    rst_n = 1'b1;
    tick();

    // 1. Single byte A5, command, last
    clear_logs();
    send0(8'hA5, 1'b0, 1'b1);
    t0 = last_acc;
    chk("t1_ss_hi_n1", ss_o[0],   1);
    chk("t1_busy_n1",  busy_o[0], 1);
    chk("t1_rdy_n1",   rdy_o[0],  0);
    tick();
    chk("t1_ss_lo_n2", ss_o[0],   0);
    chk("t1_scl_n2",   scl_o[0],  0);
    chk("t1_mosi_n2",  mosi_o[0], 1);
    chk("t1_dc_n2",    dc_o[0],   0);
    wait_cyc(t0 + 17);
    chk("t1_scl_b0hi", scl_o[0], 1);
    wait_cyc(t0 + 18);
    chk("t1_scl_fall", scl_o[0], 0);
    chk("t1_ss_hold",  ss_o[0],  0);
    wait_cyc(t0 + 19);
    chk("t1_ss_rise",  ss_o[0],  1);
    chk("t1_busy_gap", busy_o[0], 1);
    wait_cyc(t0 + 20);
    chk("t1_busy_end", busy_o[0], 0);
    chk("t1_rdy_end",  rdy_o[0],  1);
    chk("t1_rises",    rise_q0.size(), 8);
    chk("t1_rise0",    rise_q0[0], t0 + 3);
    chk("t1_rise7",    rise_q0[7], t0 + 17);
    chk("t1_nbytes",   rx_q0.size(), 1);
    chk("t1_byte",     rx_q0[0], {1'b0, 8'hA5});

    // 2. Three-byte burst
    tick();
    clear_logs();
    falls0 = ss_falls[0];
    send0(8'hAE, 1'b0, 1'b0);
    t0 = last_acc;
    send0(8'hFF, 1'b1, 1'b0);
    send0(8'h00, 1'b1, 1'b1);
    wait_rx("t2_nbytes", 0, 3, 200);
    wait_idle("t2_idle", 0);
    chk("t2_byte0",  rx_q0[0], {1'b0, 8'hAE});
    chk("t2_byte1",  rx_q0[1], {1'b1, 8'hFF});
    chk("t2_byte2",  rx_q0[2], {1'b1, 8'h00});
    chk("t2_rises",  rise_q0.size(), 24);
    chk("t2_rise0",  rise_q0[0], t0 + 3);
    chk("t2_gap01",  rise_q0[8] - rise_q0[0], 16);
    chk("t2_gap12",  rise_q0[16] - rise_q0[8], 16);
    chk("t2_ss_one", ss_falls[0] - falls0, 1);
    chk("t2_sig",    sig_bad[0], 0);

    // 3. tx_valid stuck high on the CLK_DIV=4 instance, junk while not ready
    clear_logs();
    bytes3[0] = 8'h11;
    bytes3[1] = 8'h22;
    bytes3[2] = 8'h33;
    bytes3[3] = 8'h44;
    k      = 0;
    budget = 600;
    vld[1] = 1'b1;
    while (k < 4 && budget > 0) begin
      if (rdy_o[1]) begin
        dat[1]  = bytes3[k];
        dcin[1] = k[0];
        lst[1]  = (k == 3);
        acc3[k] = cyc;
        k++;
      end else begin
        dat[1]  = 8'($urandom);
        dcin[1] = 1'($urandom);
        lst[1]  = 1'($urandom);
      end
      tick();
      budget--;
      if (k == 2 && cyc == acc3[1] + 1) chk("t3_rdy_low", rdy_o[1], 0);
    end
    vld[1] = 1'b0;
    chk("t3_accepts", k, 4);
    chk("t3_acc01", acc3[1] - acc3[0], 2);
    chk("t3_acc12", acc3[2] - acc3[1], 61);
    chk("t3_acc23", acc3[3] - acc3[2], 64);
    wait_rx("t3_nbytes", 1, 4, 400);
    wait_idle("t3_idle", 1);
    chk("t3_byte0",  rx_q1[0], {1'b0, 8'h11});
    chk("t3_byte1",  rx_q1[1], {1'b1, 8'h22});
    chk("t3_byte2",  rx_q1[2], {1'b0, 8'h33});
    chk("t3_byte3",  rx_q1[3], {1'b1, 8'h44});
    chk("t3_only4",  rx_q1.size(), 4);
    chk("t3_cad01",  rise_q1[8] - rise_q1[0], 64);
    chk("t3_cad03",  rise_q1[24] - rise_q1[0], 192);
    chk("t3_ss_one", ss_falls[1], 1);
    chk("t3_sig",    sig_bad[1], 0);

    // 4. Underrun: not-last byte with nothing behind it
    clear_logs();
    falls0 = ss_falls[0];
    send0(8'h3C, 1'b0, 1'b0);
    t0 = last_acc;
    wait_cyc(t0 + 18);
    chk("t4_ss_hold", ss_o[0], 0);
    wait_cyc(t0 + 19);
    chk("t4_ss_rise", ss_o[0], 1);
    wait_cyc(t0 + 20);
    chk("t4_ss_gap",  ss_o[0], 1);
    chk("t4_busy",    busy_o[0], 0);
    tick();
    send0(8'h5A, 1'b1, 1'b1);
    wait_rx("t4_nbytes", 0, 2, 200);
    wait_idle("t4_idle", 0);
    chk("t4_byte0",  rx_q0[0], {1'b0, 8'h3C});
    chk("t4_byte1",  rx_q0[1], {1'b1, 8'h5A});
    chk("t4_bursts", ss_falls[0] - falls0, 2);

    // 5. Reset during bit 4 of C3 with 77 held
    clear_logs();
    send0(8'hC3, 1'b0, 1'b0);
    t0 = last_acc;
    send0(8'h77, 1'b1, 1'b0);
    wait_cyc(t0 + 9);
    chk("t5_bit4_hi", scl_o[0], 1);
    chk("t5_held",    rdy_o[0], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_ss_async",  ss_o[0],  1);
    chk("t5_scl_async", scl_o[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_rdy",    rdy_o[0],  1);
    chk("t5_busy",   busy_o[0], 0);
    chk("t5_nopart", rx_q0.size(), 0);
    send0(8'h81, 1'b1, 1'b1);
    wait_rx("t5_nbytes", 0, 1, 200);
    wait_idle("t5_idle", 0);
    chk("t5_byte", rx_q0[0], {1'b1, 8'h81});
    chk("t5_only", rx_q0.size(), 1);

    // 6. Display-on command followed by a data stream
    clear_logs();
    falls0 = ss_falls[0];
    send0(8'hAF, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      send0(8'(i * 37 + 5), 1'b1, (i == 63));
    end
    wait_rx("t6_nbytes", 0, 65, 400);
    wait_idle("t6_idle", 0);
    chk("t6_cmd", rx_q0[0], {1'b0, 8'hAF});
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("t6_data%0d", i), rx_q0[i + 1], {1'b1, 8'(i * 37 + 5)});
    end
    chk("t6_ss_one", ss_falls[0] - falls0, 1);
    chk("t6_sig",    sig_bad[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
